// File: rtl/multi_scaler_if.sv
// multi_scaler_if: control, divisor-write and output bundle of the multi-channel
// clock scaler. clk_in and rst stay plain ports on the scaler itself.
// The tick vector exists only when MULTI_SCALER_TICK_EN is defined.
//
// Write handshake (valid/ready): a divisor write transfers on the rising clk_in
// edge where wr_valid && wr_ready are both high. The master may raise wr_valid
// at any time and must hold wr_sel/wr_data stable while wr_valid is high and
// wr_ready is low. wr_ready is a combinational function of wr_sel and the
// target channel's pending flag only; it never looks at wr_valid.
interface multi_scaler_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 24
);
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0] run;
  logic                sync;
  logic                wr_valid;
  logic [SEL_W-1:0]    wr_sel;
  logic [WIDTH-1:0]    wr_data;
  logic                wr_ready;
  logic [CHANNELS-1:0] clk_out;
`ifdef MULTI_SCALER_TICK_EN
  logic [CHANNELS-1:0] tick;
`endif

  modport master (
    output run, sync, wr_valid, wr_sel, wr_data,
`ifdef MULTI_SCALER_TICK_EN
    input  tick,
`endif
    input  wr_ready, clk_out
  );

  modport slave (
    input  run, sync, wr_valid, wr_sel, wr_data,
`ifdef MULTI_SCALER_TICK_EN
    output tick,
`endif
    output wr_ready, clk_out
  );
endinterface

// File: rtl/multi_scaler.sv
// multi_scaler: CHANNELS independent square-wave generators from one clk_in.
// Each channel counts 0..div and toggles clk_out on the terminal count, giving
// a half-period of div+1 cycles. New divisors are staged in pend_div and only
// take effect at a half-period boundary, on a stopped cycle or on sync, so a
// running half-period is never cut short or stretched by a write.
// Optional feature macro: MULTI_SCALER_TICK_EN adds a one-cycle rising-edge
// strobe per channel (tick).
module multi_scaler #(
  parameter int          CHANNELS    = 4,
  parameter int          WIDTH       = 24,
  parameter int unsigned DEFAULT_DIV = 12000000
) (
  input  logic          clk_in,
  input  logic          rst,
  multi_scaler_if.slave bus
);
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

  logic [CHANNELS-1:0] pending_vec;
  logic                ready_c;
  logic                wr_accept;

  // Ready follows the addressed channel's pending flag; selects beyond the
  // last channel match nothing and stay ready so the write is swallowed.
  always_comb begin
    ready_c = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.wr_sel == SEL_W'(i)) ready_c = !pending_vec[i];
    end
  end

  assign bus.wr_ready = ready_c;
  assign wr_accept    = bus.wr_valid && ready_c;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [WIDTH-1:0] counter;
    logic [WIDTH-1:0] div;
    logic [WIDTH-1:0] pend_div;
    logic             pending;
    logic             clk_q;
    logic             wr_hit;
    logic             terminal;
    logic             stop;
    logic             apply;

    assign wr_hit   = wr_accept && (bus.wr_sel == SEL_W'(g));
    assign terminal = (counter == div);
    // sync and a low run both force the channel back to its idle phase.
    assign stop     = bus.sync || !bus.run[g];
    // A staged divisor lands on any phase-restart or half-period boundary.
    assign apply    = pending && (stop || terminal);

    // Counter, output phase, active divisor and pending flag.
    always_ff @(posedge clk_in) begin
      if (rst) begin
        counter <= '0;
        clk_q   <= 1'b0;
        div     <= DIV_RST;
        pending <= 1'b0;
      end else begin
        if (stop) begin
          counter <= '0;
          clk_q   <= 1'b0;
        end else if (terminal) begin
          counter <= '0;
          clk_q   <= ~clk_q;
        end else begin
          counter <= counter + 1'b1;
        end
        if (apply) div <= pend_div;
        // wr_hit and apply are exclusive: a write needs pending low,
        // an apply needs it high.
        if (wr_hit)     pending <= 1'b1;
        else if (apply) pending <= 1'b0;
      end
    end

    // Staging register; its value is only consumed while pending is set.
    always_ff @(posedge clk_in) begin
      if (wr_hit) pend_div <= bus.wr_data;
    end

    assign pending_vec[g] = pending;
    assign bus.clk_out[g] = clk_q;

`ifdef MULTI_SCALER_TICK_EN
    logic tick_q;

    // Strobe lands in the first cycle clk_out reads 1 after a low phase.
    always_ff @(posedge clk_in) begin
      if (rst || stop) tick_q <= 1'b0;
      else             tick_q <= terminal && !clk_q;
    end

    assign bus.tick[g] = tick_q;
`endif
  end

endmodule
